bcd2bin_seq: RTL

Sequential BCD-to-binary converter, the inverse of the team's binary-to-BCD block. It accepts a packed multi-digit BCD word on a start strobe and runs the reverse double-dabble algorithm (shift right, then subtract 3 from any digit ≥ 8), one bit per clock. It returns the binary value with a one-cycle done pulse. It sits between BCD-producing front ends (keypads, display registers) and binary arithmetic logic.

---
 rtl/bcd2bin_if.sv | 23 ++
 rtl/bcd2bin_seq.sv | 101 ++++++++++
 2 files changed

// File: rtl/bcd2bin_if.sv
// Request/result bundle for the sequential BCD-to-binary converter.
// The requester drives start/bcd_in; the converter returns busy/done/bin_out/err.
interface bcd2bin_if #(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10
);
    logic                  start;
    logic [4*DIGITS-1:0]   bcd_in;
    logic                  busy;
    logic                  done;
    logic [BIN_W-1:0]      bin_out;
    logic                  err;

    modport master (
        output start, bcd_in,
        input  busy, done, bin_out, err
    );

    modport slave (
        input  start, bcd_in,
        output busy, done, bin_out, err
    );
endinterface

// File: rtl/bcd2bin_seq.sv
// Sequential BCD-to-binary converter: reverse double-dabble, one result bit per clock,
// with a registered one-cycle done pulse and immediate rejection of non-decimal digits.
module bcd2bin_seq #(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    bcd2bin_if.slave   bus
);
    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_e;

    state_e             state_q;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic [BIN_W-1:0]   bin_q, bin_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [BIN_W-1:0]   bin_out_q;
    logic               busy_q, done_q, err_q;
    logic               bad_digit;
    logic               last_shift;
    logic [BCD_W+BIN_W-1:0] shifted;

    always_comb begin
        // NOTE: every variable assigned here gets a default first, so no path leaves it unassigned and no latch is inferred.
        bad_digit = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bus.bcd_in[4*i +: 4] > 4'd9) bad_digit = 1'b1;
        end
    end

    // One reverse double-dabble step: shift the pair right, then pull each digit back below 8.
    always_comb begin
        shifted = {bcd_q, bin_q} >> 1;
        bin_d   = shifted[BIN_W-1:0];
        bcd_d   = shifted[BCD_W+BIN_W-1:BIN_W];
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_d[4*i +: 4] >= 4'd8) bcd_d[4*i +: 4] = bcd_d[4*i +: 4] - 4'd3;
        end
    end

    assign last_shift = (cnt_q == CNT_W'(BIN_W - 1));

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            bcd_q     <= '0;
            bin_q     <= '0;
            cnt_q     <= '0;
            bin_out_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        if (bad_digit) begin
                            bin_out_q <= '0;
                            err_q     <= 1'b1;
                            done_q    <= 1'b1;
                        end else begin
                            bcd_q   <= bus.bcd_in;
                            bin_q   <= '0;
                            cnt_q   <= '0;
                            busy_q  <= 1'b1;
                            state_q <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    bcd_q <= bcd_d;
                    bin_q <= bin_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (last_shift) begin
                        // Every decimal digit must have been fully drained into bin_reg.
                        assert (bcd_d == '0);
                        bin_out_q <= bin_d;
                        err_q     <= 1'b0;
                        done_q    <= 1'b1;
                        busy_q    <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.bin_out = bin_out_q;
    assign bus.err     = err_q;
endmodule
